obi_mimo_sbr: RTL and testbench
===============================

// Module: obi_mimo_sbr
// PURPOSE
// OBI subordinate (responder) that terminates requests from the accelerator's OBI manager port.
// It holds a word-addressed scratchpad of DEPTH x 32-bit registers for MIMO operand/result exchange.
// It accepts one transaction at a time and inserts WAIT_CYCLES programmable wait states.
// It returns read data or write acknowledgement with the request ID echoed. A side read port gives the accelerator datapath direct access.
// PARAMETERS
// BASE_ADDR    32'h2000_0000  byte base address; must be aligned to DEPTH*4
// DEPTH        16             number of 32-bit words; power of two, 2..256
// WAIT_CYCLES  1              extra cycles between grant and response, 0..15
// ID_W         4              width of aid/rid
// PORTS
// clk         in   1           clock, all logic on rising edge
// rst_n       in   1           asynchronous active-low reset
// obi_req     in   1           A-channel request valid
// obi_gnt     out  1           A-channel grant
// obi_addr    in   32          byte address
// obi_we      in   1           1 = write, 0 = read
// obi_be      in   4           byte enables (write only)
// obi_wdata   in   32          write data
// obi_aid     in   ID_W        request ID
// obi_rvalid  out  1           R-channel response valid (single-cycle pulse, no rready)
// obi_rdata   out  32          read data; 0 for writes and errors
// obi_err     out  1           response error flag
// obi_rid     out  ID_W        echoed request ID
// acc_raddr   in   $clog2(DEPTH)  side-port word index
// acc_rdata   out  32          mem[acc_raddr], combinational
// BEHAVIOUR
// - Reset: state=IDLE, wait counter=0, all mem words=0, captured regs=0.
// - Reset outputs: obi_gnt=0, obi_rvalid=0, obi_rdata=0, obi_err=0, obi_rid=0.
// - FSM states: IDLE, WAIT, RESP.
// - IDLE:
//   - obi_gnt = obi_req, combinational; gnt is never asserted outside IDLE.
//   - On req&gnt: capture addr, we, be, wdata, aid.
//   - Next state is WAIT with counter=WAIT_CYCLES-1, or RESP directly if WAIT_CYCLES==0.
// - WAIT: counter decrements each cycle; go to RESP when the counter reaches 0.
// - RESP: obi_rvalid=1 for exactly this one cycle, then go to IDLE unconditionally.
// - Latency: handshake in cycle T gives rvalid in cycle T+1+WAIT_CYCLES.
// - Throughput: at most one transaction per WAIT_CYCLES+2 cycles. A req held through RESP is granted on the next IDLE cycle.
// - Decode:
//   - idx = addr_q[$clog2(DEPTH)+1:2].
//   - err = (addr_q[31:$clog2(DEPTH)+2] != BASE_ADDR[31:$clog2(DEPTH)+2]) | (addr_q[1:0] != 0).
// - Read response, no error: obi_rdata = mem[idx], sampled in the RESP cycle.
// - Write response, no error:
//   - For each i, byte i of mem[idx] is updated from wdata_q if be_q[i].
//   - The update commits on the clock edge ending RESP.
//   - be_q=4'b0000 is a legal no-op with err=0.
// - Error response: obi_err=1, obi_rdata=0, mem unchanged. Reads and writes are handled identically.
// - Outside RESP: obi_rvalid=0, obi_err=0, obi_rdata=0, obi_rid=0. In RESP: obi_rid = aid_q.
// - Side port: acc_rdata reflects committed mem state. A write becomes visible the cycle after its RESP.
// - obi_req/obi_addr changes outside IDLE are ignored, since signals are captured only at handshake.
// - Reset mid-transaction: the in-flight transaction is dropped, no rvalid is issued, and no partial write lands.
// TESTING
// - Reset with req=1 held -> gnt=0, rvalid=0 during reset. With WAIT_CYCLES=1, gnt=1 in the first cycle after release.
// - Write 0x2000_0008, wdata=0xDEADBEEF, be=4'hF, aid=3:
//   - Expected: rvalid 2 cycles after handshake, err=0, rid=3, rdata=0.
//   - Then read 0x2000_0008 -> rdata=0xDEADBEEF.
// - Write 0x1122_3344 to word 2, then be=4'b0101 with wdata=0xAABBCCDD -> read returns 0x11BB_33DD; acc_raddr=2 gives the same value.
// - Out-of-range and misaligned errors:
//   - Read 0x2000_0040 (DEPTH=16) -> err=1, rdata=0, rid echoed.
//   - Write 0x2000_0005 -> err=1 and no word changes.
// - WAIT_CYCLES=0, req held continuously with 4 reads -> grants 2 cycles apart, each rvalid exactly 1 cycle after its grant, IDs in order.
// - Assert rst_n=0 during WAIT of a write to word 1 -> no rvalid; after reset, reading word 1 returns 0.

Source files
------------

// File: rtl/obi_mimo_sbr.sv
// OBI subordinate holding a DEPTH x 32-bit scratchpad for MIMO operand/result exchange.
// Serves one transaction at a time with WAIT_CYCLES wait states and has a combinational side read port.
module obi_mimo_sbr #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter int          ID_W        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     obi_req,
  output logic                     obi_gnt,
  input  logic [31:0]              obi_addr,
  input  logic                     obi_we,
  input  logic [3:0]               obi_be,
  input  logic [31:0]              obi_wdata,
  input  logic [ID_W-1:0]          obi_aid,
  output logic                     obi_rvalid,
  output logic [31:0]              obi_rdata,
  output logic                     obi_err,
  output logic [ID_W-1:0]          obi_rid,
  input  logic [$clog2(DEPTH)-1:0] acc_raddr,
  output logic [31:0]              acc_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [ID_W-1:0] aid_q;
  logic [31:0]     mem [DEPTH];

  logic          hs;
  logic [AW-1:0] idx;
  logic          dec_err;

  assign idx     = addr_q[AW+1:2];
  assign dec_err = (addr_q[31:AW+2] != BASE_ADDR[31:AW+2]) | (addr_q[1:0] != 2'b00);

  // Grant is masked by reset so a held request is not acknowledged while rst_n is low.
  assign obi_gnt = rst_n & (state_q == S_IDLE) & obi_req;
  assign hs      = obi_gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    obi_rvalid = 1'b0;
    obi_err    = 1'b0;
    obi_rdata  = '0;
    obi_rid    = '0;
    if (state_q == S_RESP) begin
      obi_rvalid = 1'b1;
      obi_err    = dec_err;
      obi_rid    = aid_q;
      if (!we_q && !dec_err) obi_rdata = mem[idx];
    end
  end

  assign acc_rdata = mem[acc_raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      aid_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        addr_q  <= obi_addr;
        we_q    <= obi_we;
        be_q    <= obi_be;
        wdata_q <= obi_wdata;
        aid_q   <= obi_aid;
      end
    end
  end

  // Writes commit on the edge that ends RESP, so the side port sees them one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == S_RESP && we_q && !dec_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_obi_mimo_sbr.sv
// Directed self-checking bench for obi_mimo_sbr: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=0.
module tb_obi_mimo_sbr;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        obi_req, obi_gnt, obi_we, obi_rvalid, obi_err;
  logic [31:0] obi_addr, obi_wdata, obi_rdata, acc_rdata;
  logic [3:0]  obi_be, obi_aid, obi_rid, acc_raddr;

  logic        b_req, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr, b_rdata, b_acc_rdata;
  logic [3:0]  b_aid, b_rid;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] resp_acc;

  always #5 clk = ~clk;

  obi_mimo_sbr #(
    .BASE_ADDR  (32'h2000_0000),
    .DEPTH      (16),
    .WAIT_CYCLES(1),
    .ID_W       (4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .obi_req   (obi_req),
    .obi_gnt   (obi_gnt),
    .obi_addr  (obi_addr),
    .obi_we    (obi_we),
    .obi_be    (obi_be),
    .obi_wdata (obi_wdata),
    .obi_aid   (obi_aid),
    .obi_rvalid(obi_rvalid),
    .obi_rdata (obi_rdata),
    .obi_err   (obi_err),
    .obi_rid   (obi_rid),
    .acc_raddr (acc_raddr),
    .acc_rdata (acc_rdata)
  );

  obi_mimo_sbr #(
    .BASE_ADDR  (32'h2000_0000),
    .DEPTH      (16),
    .WAIT_CYCLES(0),
    .ID_W       (4)
  ) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .obi_req   (b_req),
    .obi_gnt   (b_gnt),
    .obi_addr  (b_addr),
    .obi_we    (1'b0),
    .obi_be    (4'h0),
    .obi_wdata (32'h0),
    .obi_aid   (b_aid),
    .obi_rvalid(b_rvalid),
    .obi_rdata (b_rdata),
    .obi_err   (b_err),
    .obi_rid   (b_rid),
    .acc_raddr (4'd0),
    .acc_rdata (b_acc_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Caller is just after a rising edge with the DUT in IDLE.
  task automatic txn(input string tag, input logic [31:0] a, input logic w, input logic [3:0] be,
                     input logic [31:0] wd, input logic [3:0] id,
                     input logic [31:0] exp_rd, input logic exp_err);
    int unsigned n;
    obi_req = 1'b1; obi_addr = a; obi_we = w; obi_be = be; obi_wdata = wd; obi_aid = id;
    @(negedge clk);
    chk({tag, ".gnt"}, 32'(obi_gnt), 32'd1);
    @(posedge clk); #1;
    // Garbage after the handshake must be ignored.
    obi_req = 1'b0; obi_addr = 32'hFFFF_FFFF; obi_we = ~w; obi_be = ~be; obi_wdata = ~wd; obi_aid = ~id;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!obi_rvalid) chk({tag, ".gnt_busy"}, 32'(obi_gnt), 32'd0);
    end while (!obi_rvalid && n < 8);
    chk({tag, ".lat"},   n, 32'd2);
    chk({tag, ".err"},   32'(obi_err), 32'(exp_err));
    chk({tag, ".rid"},   32'(obi_rid), 32'(id));
    chk({tag, ".rdata"}, obi_rdata, exp_rd);
    resp_acc = acc_rdata;
    @(posedge clk); #1;
    obi_addr = 32'h0; obi_we = 1'b0; obi_be = 4'h0; obi_wdata = 32'h0; obi_aid = 4'h0;
    @(negedge clk);
    chk({tag, ".rvalid_off"}, 32'(obi_rvalid), 32'd0);
    @(posedge clk); #1;
  endtask

  int unsigned g_cyc [4];
  int unsigned gcount, rcount, cyc;
  logic        saw_gnt;

  initial begin
    rst_n = 1'b0;
    obi_req = 1'b1; obi_addr = 32'h2000_0000; obi_we = 1'b0; obi_be = 4'h0;
    obi_wdata = 32'h0; obi_aid = 4'h5; acc_raddr = 4'd2;
    b_req = 1'b0; b_addr = 32'h2000_0000; b_aid = 4'h0;

    repeat (2) @(negedge clk);
    chk("rst.gnt",    32'(obi_gnt),    32'd0);
    chk("rst.rvalid", 32'(obi_rvalid), 32'd0);
    chk("rst.rdata",  obi_rdata,       32'd0);
    chk("rst.err",    32'(obi_err),    32'd0);
    chk("rst.rid",    32'(obi_rid),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn("rst_rd", 32'h2000_0000, 1'b0, 4'h0, 32'h0, 4'h5, 32'h0, 1'b0);

    txn("wr8", 32'h2000_0008, 1'b1, 4'hF, 32'hDEAD_BEEF, 4'h3, 32'h0, 1'b0);
    chk("wr8.acc_in_resp", resp_acc, 32'h0);
    chk("wr8.acc_after",   acc_rdata, 32'hDEAD_BEEF);
    txn("rd8", 32'h2000_0008, 1'b0, 4'h0, 32'h0, 4'h9, 32'hDEAD_BEEF, 1'b0);

    txn("wr_full", 32'h2000_0008, 1'b1, 4'hF, 32'h1122_3344, 4'h1, 32'h0, 1'b0);
    txn("wr_be5",  32'h2000_0008, 1'b1, 4'b0101, 32'hAABB_CCDD, 4'h2, 32'h0, 1'b0);
    txn("rd_be5",  32'h2000_0008, 1'b0, 4'h0, 32'h0, 4'h4, 32'h11BB_33DD, 1'b0);
    chk("acc_be5", acc_rdata, 32'h11BB_33DD);

    txn("wr_be0", 32'h2000_0008, 1'b1, 4'h0, 32'h0000_0000, 4'h6, 32'h0, 1'b0);
    chk("acc_be0", acc_rdata, 32'h11BB_33DD);

    txn("rd_oor",  32'h2000_0040, 1'b0, 4'h0, 32'h0, 4'h7, 32'h0, 1'b1);
    txn("wr_mis",  32'h2000_0005, 1'b1, 4'hF, 32'h5555_5555, 4'h8, 32'h0, 1'b1);
    txn("rd_w1",   32'h2000_0004, 1'b0, 4'h0, 32'h0, 4'hA, 32'h0, 1'b0);
    txn("rd_w2",   32'h2000_0008, 1'b0, 4'h0, 32'h0, 4'hB, 32'h11BB_33DD, 1'b0);
    txn("wr_oor",  32'h2000_0048, 1'b1, 4'hF, 32'h7777_7777, 4'hC, 32'h0, 1'b1);
    txn("rd_w2b",  32'h2000_0008, 1'b0, 4'h0, 32'h0, 4'hD, 32'h11BB_33DD, 1'b0);

    // Reset during the wait state of a write to word 1.
    obi_req = 1'b1; obi_addr = 32'h2000_0004; obi_we = 1'b1; obi_be = 4'hF;
    obi_wdata = 32'hCAFE_F00D; obi_aid = 4'h2;
    @(posedge clk); #1;
    obi_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst.rvalid", 32'(obi_rvalid), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_raddr = 4'd1;
    @(negedge clk);
    chk("midrst.acc_w1", acc_rdata, 32'h0);
    @(posedge clk); #1;
    txn("midrst.rd_w1", 32'h2000_0004, 1'b0, 4'h0, 32'h0, 4'h1, 32'h0, 1'b0);
    txn("midrst.rd_w2", 32'h2000_0008, 1'b0, 4'h0, 32'h0, 4'h2, 32'h0, 1'b0);

    // WAIT_CYCLES=0 instance: request held across four reads.
    b_req = 1'b1; b_aid = 4'd0; b_addr = 32'h2000_0000;
    gcount = 0; rcount = 0; cyc = 0;
    while (rcount < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      saw_gnt = b_gnt;
      if (b_gnt && b_rvalid) chk("w0.gnt_rvalid_overlap", 32'd1, 32'd0);
      if (b_gnt && gcount < 4) begin
        g_cyc[gcount] = cyc;
        if (gcount > 0) chk("w0.gnt_gap", cyc - g_cyc[gcount-1], 32'd2);
        gcount++;
      end
      if (b_rvalid && rcount < gcount) begin
        chk("w0.rid",   32'(b_rid), rcount);
        chk("w0.rlat",  cyc, g_cyc[rcount] + 1);
        chk("w0.err",   32'(b_err), 32'd0);
        chk("w0.rdata", b_rdata, 32'h0);
        rcount++;
      end
      @(posedge clk); #1;
      if (saw_gnt) begin
        b_aid  = 4'(gcount);
        b_addr = 32'h2000_0000 + 32'(gcount * 4);
        if (gcount == 4) b_req = 1'b0;
      end
    end
    chk("w0.n_resp",  rcount, 32'd4);
    chk("w0.n_grant", gcount, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
